// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the CNN output-buffer fill logic.
//   DEF_ADDR_W / DEF_SIZE_W / DEF_MAX_CH : default widths and channel limit
//   fill_state_e                         : output_fill_ctrl FSM encoding
//   ch_width()                           : channel-index width, never below 1
package cnn_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_SIZE_W = 8;
    localparam int DEF_MAX_CH = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_EMPTY = 3'd1,
        FILL_RD    = 3'd2,
        FILL_WR    = 3'd3,
        DONE       = 3'd4
    } fill_state_e;

    // A single channel still needs a 1-bit index so ports never collapse to zero width.
    function automatic int ch_width(input int max_ch);
        return (max_ch > 1) ? $clog2(max_ch) : 1;
    endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: up-counter with synchronous clear, increment and terminal flag.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : synchronous clear (priority over increment)
//   inc_i        : advance by one; at terminal value the counter returns to 0
//   last_i       : terminal value
//   count_o      : current count
//   tc_o         : count_o == last_i
module fill_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc_o    = (count_q == last_i);
    assign count_o = count_q;

    // Next count: clear, wrap at terminal, or step.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            if (tc_o) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/output_fill_ctrl.sv
// output_fill_ctrl: walks an output buffer region, writing one feature-map
// datum per consumed input, optionally reading each location first so an
// external adder (1-cycle read latency) can accumulate into it.
//   w_clk, reset                 : clock, async active-high reset
//   enable                       : run/pause; 0 freezes the fill and gates strobes
//   start                        : fill request, honoured only in IDLE
//   accumulate, initial_address,
//   output_featuremapsize,
//   num_channels                 : fill description, sampled at start
//   is_empty                     : destination drained, safe to overwrite
//   in_valid / in_ready          : input datum handshake
//   c_address                    : current buffer address
//   write_enable / read_enable   : buffer strobes, mutually exclusive
//   ch_idx                       : current channel
//   busy / done                  : fill in progress / one-cycle completion
module output_fill_ctrl
    import cnn_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SIZE_W = DEF_SIZE_W,
    parameter int MAX_CH = DEF_MAX_CH,
    localparam int CH_W  = ch_width(MAX_CH)
) (
    input  logic              w_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              accumulate,
    input  logic [ADDR_W-1:0] initial_address,
    input  logic [SIZE_W-1:0] output_featuremapsize,
    input  logic [CH_W:0]     num_channels,
    input  logic              is_empty,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] c_address,
    output logic              write_enable,
    output logic              read_enable,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
    output logic              done
);

    fill_state_e       state_q, state_d;
    logic              accum_q, accum_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [CH_W:0]     nch_q, nch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              start_s;
    logic              consume_s;
    logic              elem_tc_s;
    logic              ch_tc_s;
    logic [SIZE_W-1:0] elem_cnt_unused_s;
    logic [SIZE_W-1:0] elem_last_s;
    logic [CH_W-1:0]   ch_last_s;

    assign start_s     = (state_q == IDLE) && enable && start;
    assign consume_s   = (state_q == FILL_WR) && enable && in_valid;
    assign elem_last_s = size_q - SIZE_W'(1);
    assign ch_last_s   = CH_W'(nch_q - (CH_W + 1)'(1));

    // Channel advances on the datum that completes a channel's elements.
    fill_counter #(.W(SIZE_W)) u_elem_cnt (
        .clk_i   (w_clk),
        .rst_i   (reset),
        .clr_i   (start_s),
        .inc_i   (consume_s),
        .last_i  (elem_last_s),
        .count_o (elem_cnt_unused_s),
        .tc_o    (elem_tc_s)
    );

    fill_counter #(.W(CH_W)) u_ch_cnt (
        .clk_i   (w_clk),
        .rst_i   (reset),
        .clr_i   (start_s),
        .inc_i   (consume_s && elem_tc_s),
        .last_i  (ch_last_s),
        .count_o (ch_idx),
        .tc_o    (ch_tc_s)
    );

    // Next-state, latched fill description, address and strobes.
    always_comb begin
        state_d      = state_q;
        accum_d      = accum_q;
        size_d       = size_q;
        nch_d        = nch_q;
        addr_d       = addr_q;
        in_ready     = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    accum_d = accumulate;
                    size_d  = output_featuremapsize;
                    nch_d   = num_channels;
                    addr_d  = initial_address;
                    if ((output_featuremapsize == '0) || (num_channels == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_EMPTY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_EMPTY: begin
                if (enable && is_empty) begin
                    state_d = accum_q ? FILL_RD : FILL_WR;
                end else begin
                    state_d = WAIT_EMPTY;
                end
            end
            FILL_RD: begin
                // Read the old value; the write of the sum follows at the same address.
                read_enable = enable;
                if (enable) begin
                    state_d = FILL_WR;
                end else begin
                    state_d = FILL_RD;
                end
            end
            FILL_WR: begin
                in_ready     = consume_s;
                write_enable = consume_s;
                if (consume_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (elem_tc_s && ch_tc_s) begin
                        state_d = DONE;
                    end else if (accum_q) begin
                        state_d = FILL_RD;
                    end else begin
                        state_d = FILL_WR;
                    end
                end else begin
                    state_d = FILL_WR;
                end
            end
            // DONE always retires after one cycle so done is a true single pulse.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge w_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            accum_q <= 1'b0;
            size_q  <= '0;
            nch_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            accum_q <= accum_d;
            size_q  <= size_d;
            nch_q   <= nch_d;
            addr_q  <= addr_d;
        end
    end

    assign c_address = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_output_fill_ctrl.sv
// tb_output_fill_ctrl: table-driven and randomized fills checked against a
// transaction-level model (expected ordered list of buffer accesses per fill),
// plus hand-written enable-freeze and mid-fill reset sequences.
module tb_output_fill_ctrl;

    logic       w_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start;
    logic       accumulate;
    logic [9:0] initial_address;
    logic [7:0] output_featuremapsize;
    logic [2:0] num_channels;
    logic       is_empty;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] c_address;
    logic       write_enable;
    logic       read_enable;
    logic [1:0] ch_idx;
    logic       busy;
    logic       done;

    int tests  = 0;
    int failed = 0;

    output_fill_ctrl dut (
        .w_clk                 (w_clk),
        .reset                 (reset),
        .enable                (enable),
        .start                 (start),
        .accumulate            (accumulate),
        .initial_address       (initial_address),
        .output_featuremapsize (output_featuremapsize),
        .num_channels          (num_channels),
        .is_empty              (is_empty),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .c_address             (c_address),
        .write_enable          (write_enable),
        .read_enable           (read_enable),
        .ch_idx                (ch_idx),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 w_clk = ~w_clk;

    // Monitor: every buffer access as {is_write, address}, plus rule violations.
    logic [10:0] op_q[$];
    logic [1:0]  ch_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, last_strobe = 0;
    int viol_busy = 0, viol_both = 0, viol_en = 0, viol_val = 0, viol_rdy = 0;
    bit track = 1'b0;

    always @(negedge w_clk) begin
        if (reset) begin
            track = 1'b0;
        end else begin
            if (track && !busy) viol_busy++;
            if (write_enable && read_enable) viol_both++;
            if ((write_enable || read_enable || in_ready) && !enable) viol_en++;
            if (write_enable && !in_valid) viol_val++;
            if (in_ready != write_enable) viol_rdy++;
            if (write_enable) begin
                op_q.push_back({1'b1, c_address});
                ch_q.push_back(ch_idx);
                last_strobe = cyc;
            end
            if (read_enable) begin
                op_q.push_back({1'b0, c_address});
                last_strobe = cyc;
            end
            if (start && enable && !busy) begin
                track     = 1'b1;
                start_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                track    = 1'b0;
            end
        end
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete fill with random enable/in_valid gaps and an is_empty delay.
    task automatic run_fill(input string tag, input logic [9:0] base, input logic [7:0] size,
                            input logic [2:0] nch, input logic acc, input int p_en,
                            input int p_val, input int dly, input int exp_wr,
                            input int exp_rd, input logic [9:0] exp_final);
        logic [10:0] mq[$];
        logic [1:0]  mch[$];
        logic [9:0]  a;
        int total, ob, cb, dc0, vb0, vo0, ve0, vv0, vr0, nmis, nwr, nrd, exp_done;
        bit timeout;
        total = ((size == 8'd0) || (nch == 3'd0)) ? 0 : int'(size) * int'(nch);
        for (int i = 0; i < total; i++) begin
            a = base + 10'(i);
            if (acc) mq.push_back({1'b0, a});
            mq.push_back({1'b1, a});
            mch.push_back(2'(i / int'(size)));
        end
        ob = op_q.size(); cb = ch_q.size(); dc0 = done_cnt;
        vb0 = viol_busy; vo0 = viol_both; ve0 = viol_en; vv0 = viol_val; vr0 = viol_rdy;

        start = 1'b1; enable = 1'b1; accumulate = acc; initial_address = base;
        output_featuremapsize = size; num_channels = nch;
        is_empty = (dly == 0); in_valid = ($urandom_range(0, 99) < p_val);
        timeout = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge w_clk); #1;
            start = 1'b0;
            if (done_cnt > dc0) begin
                timeout = 1'b0;
                break;
            end
            enable   = ($urandom_range(0, 99) < p_en);
            in_valid = ($urandom_range(0, 99) < p_val);
            is_empty = (k >= dly);
        end
        check({tag, " timeout"}, 32'(timeout), 32'd0);
        check({tag, " final_addr"}, 32'(c_address), 32'(exp_final));
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        enable = 1'b1;
        @(posedge w_clk); #1;
        check({tag, " done_pulses"}, 32'(done_cnt - dc0), 32'd1);

        nwr = 0; nrd = 0; nmis = 0;
        for (int i = ob; i < op_q.size(); i++) begin
            if (op_q[i][10]) nwr++; else nrd++;
        end
        check({tag, " writes"}, 32'(nwr), 32'(exp_wr));
        check({tag, " reads"}, 32'(nrd), 32'(exp_rd));
        check({tag, " op_count"}, 32'(op_q.size() - ob), 32'(mq.size()));
        for (int i = 0; (i < mq.size()) && (ob + i < op_q.size()); i++) begin
            if (op_q[ob + i] !== mq[i]) nmis++;
        end
        check({tag, " op_seq"}, 32'(nmis), 32'd0);
        nmis = 0;
        for (int i = 0; (i < mch.size()) && (cb + i < ch_q.size()); i++) begin
            if (ch_q[cb + i] !== mch[i]) nmis++;
        end
        check({tag, " ch_seq"}, 32'(nmis), 32'd0);
        exp_done = (total == 0) ? start_cyc + 1 : last_strobe + 1;
        check({tag, " done_timing"}, 32'(done_cyc), 32'(exp_done));
        check({tag, " rules"}, 32'((viol_busy - vb0) + (viol_both - vo0) + (viol_en - ve0)
                                 + (viol_val - vv0) + (viol_rdy - vr0)), 32'd0);
    endtask

    typedef struct {
        logic [9:0] base;
        logic [7:0] size;
        logic [2:0] nch;
        logic       acc;
        int         p_en, p_val, dly, exp_wr, exp_rd;
        logic [9:0] exp_final;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ob, nmis, cnt;
        logic [9:0] rb;
        logic [7:0] rs;
        logic [2:0] rn;
        logic       ra;

        tbl[0] = '{10'h3F0, 8'd8, 3'd2, 1'b0, 100, 100, 0, 16, 0, 10'h000};
        tbl[1] = '{10'h3FC, 8'd8, 3'd1, 1'b0, 100, 100, 0,  8, 0, 10'h004};
        tbl[2] = '{10'h100, 8'd3, 3'd1, 1'b1, 100, 100, 0,  3, 3, 10'h103};
        tbl[3] = '{10'h055, 8'd0, 3'd2, 1'b0, 100, 100, 0,  0, 0, 10'h055};
        tbl[4] = '{10'h020, 8'd4, 3'd0, 1'b0, 100, 100, 0,  0, 0, 10'h020};
        tbl[5] = '{10'h200, 8'd4, 3'd2, 1'b0, 100, 100, 5,  8, 0, 10'h208};
        tbl[6] = '{10'h2F0, 8'd5, 3'd3, 1'b0, 100,  50, 0, 15, 0, 10'h2FF};
        tbl[7] = '{10'h3FE, 8'd2, 3'd4, 1'b1,  70,  70, 2,  8, 8, 10'h006};

        reset = 1'b1; enable = 1'b1; start = 1'b0; accumulate = 1'b0;
        initial_address = 10'h3AA; output_featuremapsize = 8'd4; num_channels = 3'd1;
        is_empty = 1'b1; in_valid = 1'b1;
        repeat (2) @(posedge w_clk);
        #1;
        check("rst c_address", 32'(c_address), 32'd0);
        check("rst ch_idx", 32'(ch_idx), 32'd0);
        check("rst busy_done", 32'({busy, done}), 32'd0);
        check("rst strobes", 32'({in_ready, write_enable, read_enable}), 32'd0);
        reset = 1'b0;
        @(posedge w_clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_fill($sformatf("vec%0d", v), tbl[v].base, tbl[v].size, tbl[v].nch, tbl[v].acc,
                     tbl[v].p_en, tbl[v].p_val, tbl[v].dly, tbl[v].exp_wr, tbl[v].exp_rd,
                     tbl[v].exp_final);
        end

        // Enable low for 3 cycles mid-fill: address frozen, no strobes.
        ob = op_q.size();
        start = 1'b1; enable = 1'b1; accumulate = 1'b0; initial_address = 10'h040;
        output_featuremapsize = 8'd8; num_channels = 3'd1; is_empty = 1'b1; in_valid = 1'b1;
        @(posedge w_clk); #1;
        start = 1'b0;
        cnt = 0;
        while ((op_q.size() - ob < 3) && (cnt < 50)) begin
            @(posedge w_clk); #1;
            cnt++;
        end
        check("freeze reach3", 32'(op_q.size() - ob), 32'd3);
        enable = 1'b0;
        nmis = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge w_clk);
            if (c_address !== 10'h043) nmis++;
            if (write_enable || read_enable || in_ready) nmis++;
        end
        check("freeze hold", 32'(nmis), 32'd0);
        @(posedge w_clk); #1;
        enable = 1'b1;
        cnt = 0;
        while (!done && (cnt < 50)) begin
            @(negedge w_clk);
            cnt++;
        end
        check("freeze done", 32'(done), 32'd1);
        @(posedge w_clk); #1;
        check("freeze final", 32'(c_address), 32'h048);
        check("freeze writes", 32'(op_q.size() - ob), 32'd8);
        nmis = 0;
        for (int i = 0; (i < 8) && (ob + i < op_q.size()); i++) begin
            rb = 10'h040 + 10'(i);
            if (op_q[ob + i] !== {1'b1, rb}) nmis++;
        end
        check("freeze addrs", 32'(nmis), 32'd0);

        // Reset after 4 writes: everything clears at once, then a clean refill.
        ob = op_q.size();
        start = 1'b1; enable = 1'b1; accumulate = 1'b0; initial_address = 10'h3F0;
        output_featuremapsize = 8'd8; num_channels = 3'd2; is_empty = 1'b1; in_valid = 1'b1;
        @(posedge w_clk); #1;
        start = 1'b0;
        cnt = 0;
        while ((op_q.size() - ob < 4) && (cnt < 50)) begin
            @(posedge w_clk); #1;
            cnt++;
        end
        check("rstmid reach4", 32'(op_q.size() - ob), 32'd4);
        reset = 1'b1;
        #1;
        check("rstmid c_address", 32'(c_address), 32'd0);
        check("rstmid flags", 32'({busy, done, in_ready, write_enable, read_enable, ch_idx}), 32'd0);
        @(posedge w_clk); #1;
        reset = 1'b0;
        @(posedge w_clk); #1;
        run_fill("rstmid refill", 10'h3F0, 8'd8, 3'd2, 1'b0, 100, 100, 0, 16, 0, 10'h000);

        // Randomized fills against the transaction model.
        for (int r = 0; r < 20; r++) begin
            rb = 10'($urandom_range(0, 1023));
            rs = 8'($urandom_range(1, 6));
            rn = 3'($urandom_range(1, 4));
            ra = 1'($urandom_range(0, 1));
            run_fill($sformatf("rand%0d", r), rb, rs, rn, ra, $urandom_range(60, 100),
                     $urandom_range(40, 100), $urandom_range(0, 4), int'(rs) * int'(rn),
                     ra ? int'(rs) * int'(rn) : 0, rb + 10'(int'(rs) * int'(rn)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/output_fill_ctrl.md
OUTPUT_FILL_CTRL -- requirements
Module: output_fill_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: width of the buffer address.
REQ-002 Parameter SIZE_W, default 8: width of the per-channel element count.
REQ-003 Parameter MAX_CH, default 4: maximum channels per fill; CH_W = clog2(MAX_CH), minimum 1.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Clock and reset ports SHALL be:
- w_clk  in  1  clock
- reset  in  1  async active-high reset
REQ-006 Control inputs SHALL be:
- enable  in  1  run/pause qualifier
- start  in  1  one-cycle fill request
- accumulate  in  1  read-modify-write mode, sampled at start
- initial_address  in  ADDR_W  base address, sampled at start
- output_featuremapsize  in  SIZE_W  elements per channel, sampled at start
- num_channels  in  CH_W+1  channels to fill (1..MAX_CH), sampled at start
- is_empty  in  1  destination buffer drained, safe to overwrite
- in_valid  in  1  output-feature-map datum available
REQ-007 Outputs SHALL be:
- in_ready  out  1  datum consumed this cycle
- c_address  out  ADDR_W  current buffer address
- write_enable  out  1  buffer write strobe
- read_enable  out  1  buffer read strobe (accumulate mode only)
- ch_idx  out  CH_W  current channel
- busy  out  1  fill in progress
- done  out  1  one-cycle completion pulse

Function
REQ-008 FSM states SHALL be IDLE, WAIT_EMPTY, FILL_RD, FILL_WR and DONE.
REQ-009 In IDLE, start=1 SHALL latch the start-sampled inputs, load c_address=initial_address, and go to WAIT_EMPTY on the next edge.
REQ-010 start outside IDLE SHALL be ignored.
REQ-011 If output_featuremapsize=0 or num_channels=0 at start, the FSM SHALL go IDLE->DONE with no strobes.
REQ-012 WAIT_EMPTY SHALL go to FILL_WR (accumulate=0) or FILL_RD (accumulate=1) on the edge after is_empty=1 and enable=1 are sampled.
REQ-013 In FILL_WR: in_ready = write_enable = enable & in_valid, combinational from state.
- c_address is a register; data is written at the address present in that cycle.
REQ-014 In FILL_RD: read_enable = enable, and no datum is consumed.
- With enable=1 the FSM goes to FILL_WR at the same c_address.
- The external adder has 1-cycle read latency.
REQ-015 In accumulate mode, a FILL_WR cycle that consumes a datum SHALL return to FILL_RD unless it was the last element.
- A FILL_WR cycle without in_valid SHALL stay in FILL_WR.
REQ-016 Each consumed datum SHALL increment c_address by 1, modulo 2^ADDR_W (wrap permitted, no error).
- Channels are contiguous: channel c occupies base + c*size .. base + (c+1)*size - 1.
REQ-017 The element counter SHALL reach size-1 and then clear, incrementing ch_idx.
- A consumed datum with element=size-1 and ch_idx=num_channels-1 SHALL go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE; c_address holds its last value plus 1.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 enable=0 SHALL freeze the state, counters and c_address.
- in_ready, write_enable and read_enable are forced to 0 while enable=0.
REQ-021 read_enable and write_enable SHALL never be high in the same cycle.

Reset
REQ-022 reset=1 SHALL asynchronously force IDLE, c_address=0, ch_idx=0, element count=0, busy=0 and done=0.
- in_ready, write_enable and read_enable are 0 while reset=1.
REQ-023 Reset mid-fill SHALL abort without a done pulse; the next start begins a fresh fill.

Structure
REQ-024 The FSM state encoding and default ADDR_W/SIZE_W/MAX_CH constants SHALL live in the shared package cnn_pkg.
REQ-025 One sub-module, fill_counter, SHALL be instantiated twice: element counter and channel counter.
- fill_counter is a parametrised up-counter with clear, increment and a terminal-count flag.

Verification
REQ-026 Base fill, no accumulate:
- Stimulus: base=0x3F0, size=8, ch=2, in_valid=1, is_empty=1.
- Response: 16 writes at 0x3F0..0x3FF, ch_idx goes 0->1 after 8 writes, done one cycle after the last write.
REQ-027 Wrap: base=0x3FC, size=8, ch=1 -> addresses 0x3FC..0x3FF then 0x000..0x003.
REQ-028 Accumulate: size=3, ch=1 -> alternating rd/wr pairs on addresses A, A+1, A+2 (6 strobe cycles), never simultaneous.
REQ-029 Stall and gating:
- is_empty=0 for 5 cycles -> no strobes and busy=1 during the wait.
- enable low mid-FILL for 3 cycles -> address frozen, no strobes.
- in_valid gaps -> writes occur only on valid cycles.
REQ-030 Zero size: size=0 -> done 1 cycle after start, no strobes.
REQ-031 Reset mid-fill: reset after 4 writes -> all outputs 0 immediately; a new start repeats a full fill with no stale state.
